// File: rtl/lock_pkg.sv
// lock_pkg: shared constants and types for the lock sequencer.
//   CODE_LEN : number of digits in one code attempt
//   state_e  : sequencer FSM states
//   sat_inc2 : 2-bit saturating increment used for the failure counter
package lock_pkg;

    localparam int unsigned CODE_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_CHECK,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_e;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter with a zero flag.
//   clk     : rising-edge clock
//   clear_n : synchronous active-low reset (counter -> 0)
//   load_i  : load val_i this cycle (takes priority over dec_i)
//   val_i   : load value
//   dec_i   : decrement by one; holds at zero instead of wrapping
//   zero_o  : counter currently equals zero
module lock_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: collects a 4-digit keypad code, presents it to an attached
// lock one digit per cycle, tracks consecutive failures and enforces a
// lockout period after too many of them.
//   clk          : rising-edge clock
//   clear_n      : synchronous active-low reset
//   key_valid    : keypad digit offered
//   key_data     : keypad digit value
//   key_ready    : digit accepted this cycle (IDLE with buffer not full)
//   lock_sw      : digit driven to the lock (0 outside PRESENT)
//   lock_clear   : active-high clear to the lock
//   lock_alarm   : lock alarm, active-low
//   lock_locked  : lock status, 0 = open
//   lock_entimer : lock open-timer running
//   open         : registered, high while in OPEN
//   lockout      : registered, high while in LOCKOUT
//   fail_cnt     : registered consecutive-failure count
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned OPEN_TIMEOUT   = 32
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       key_valid,
    input  logic [2:0] key_data,
    output logic       key_ready,
    output logic [2:0] lock_sw,
    output logic       lock_clear,
    input  logic       lock_alarm,
    input  logic       lock_locked,
    input  logic       lock_entimer,
    output logic       open,
    output logic       lockout,
    output logic [1:0] fail_cnt
);

    localparam int unsigned TMAX = (OPEN_TIMEOUT > LOCKOUT_CYCLES) ? OPEN_TIMEOUT : LOCKOUT_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned IW   = $clog2(CODE_LEN);
    localparam int unsigned CW   = $clog2(CODE_LEN + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(CODE_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(CODE_LEN - 1);
    localparam logic [1:0]    FAIL_LIM = 2'(MAX_FAIL);

    state_e        state_q, state_d;
    logic [2:0]    buf_q [CODE_LEN];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    fail_q, fail_d;
    logic          open_q, open_d;
    logic          lockout_q, lockout_d;

    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_val;

    // Any wrong-code outcome is handled identically, and the lock's own
    // timer status is informational only.
    logic unused_lock_status;
    assign unused_lock_status = lock_alarm ^ lock_entimer;

    lock_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .clear_n(clear_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        fail_d     = fail_q;
        key_ready  = 1'b0;
        lock_clear = 1'b0;
        lock_sw    = '0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lock_clear = 1'b1;
                key_ready  = (cnt_q < CNT_FULL);
                if (key_valid && key_ready) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == CNT_FULL) begin
                    state_d = ST_PRESENT;
                    idx_d   = '0;
                end
            end
            ST_PRESENT: begin
                lock_sw = buf_q[idx_q];
                if (idx_q == IDX_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_CHECK: begin
                if (!lock_locked) begin
                    state_d  = ST_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(OPEN_TIMEOUT - 1);
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_OPEN: begin
                fail_d  = '0;
                tmr_dec = 1'b1;
                if (lock_locked || tmr_zero) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                lock_clear = 1'b1;
                fail_d     = sat_inc2(fail_q);
                cnt_d      = '0;
                if (fail_d >= FAIL_LIM) begin
                    state_d  = ST_LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LOCKOUT_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                lock_clear = 1'b1;
                tmr_dec    = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset overrides the lock-facing outputs combinationally so the
        // lock is cleared in the very cycle reset is asserted.
        if (!clear_n) begin
            lock_clear = 1'b1;
            key_ready  = 1'b0;
            lock_sw    = '0;
        end

        open_d    = (state_d == ST_OPEN);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            fail_q    <= '0;
            open_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            fail_q    <= fail_d;
            open_q    <= open_d;
            lockout_q <= lockout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
                buf_q[i] <= '0;
            end
        end else if (key_valid && key_ready) begin
            buf_q[cnt_q[IW-1:0]] <= key_data;
        end
    end

    assign open     = open_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;

    localparam int T_OPEN = 32;
    localparam int T_LOCK = 16;
    localparam int MAXF   = 3;
    localparam logic [11:0] SECRET = 12'o0123;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       key_valid;
    logic [2:0] key_data;
    logic       key_ready;
    logic [2:0] lock_sw;
    logic       lock_clear;
    logic       lock_alarm;
    logic       lock_locked;
    logic       lock_entimer;
    logic       open;
    logic       lockout;
    logic [1:0] fail_cnt;

    always #5 clk = ~clk;

    lock_sequencer #(
        .MAX_FAIL      (MAXF),
        .LOCKOUT_CYCLES(T_LOCK),
        .OPEN_TIMEOUT  (T_OPEN)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .key_ready   (key_ready),
        .lock_sw     (lock_sw),
        .lock_clear  (lock_clear),
        .lock_alarm  (lock_alarm),
        .lock_locked (lock_locked),
        .lock_entimer(lock_entimer),
        .open        (open),
        .lockout     (lockout),
        .fail_cnt    (fail_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Lock model: takes 4 digits while not cleared, opens on the secret,
    // raises the alarm otherwise; relocks after `hold` open cycles.
    int          hold = 1000;
    int          lk_n = 0;
    int          lk_open = 0;
    logic [11:0] lk_got = '0;

    always @(posedge clk) begin
        if (lock_clear) begin
            lk_n        <= 0;
            lk_open     <= 0;
            lock_locked <= 1'b1;
            lock_alarm  <= 1'b1;
        end else if (lock_locked && lk_n < 4) begin
            lk_n   <= lk_n + 1;
            lk_got <= {lk_got[8:0], lock_sw};
            if (lk_n == 3) begin
                if ({lk_got[8:0], lock_sw} == SECRET) lock_locked <= 1'b0;
                else lock_alarm <= 1'b0;
            end
        end else if (!lock_locked) begin
            lk_open <= lk_open + 1;
            if (lk_open + 1 == hold) lock_locked <= 1'b1;
        end
    end

    assign lock_entimer = ~lock_locked;

    typedef struct {
        logic [11:0] code;
        bit          opened;
        int          open_len;
        int          fail_after;
        bit          locks;
    } exp_t;

    exp_t exp_q[$];
    int   done   = 0;
    bit   mon_en = 1'b1;
    int   fails  = 0;

    // Monitor: an attempt starts when lock_clear drops; observe the
    // presented digits and the outcome, compare against the queue.
    initial begin
        exp_t        e;
        logic [11:0] got;
        int          n;
        int          bad;
        forever begin
            @(negedge clk);
            if (!(mon_en && clear_n && !lock_clear)) continue;
            got = {9'd0, lock_sw};
            for (int i = 1; i < 4; i++) begin
                @(negedge clk);
                got = {got[8:0], lock_sw};
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_attempt", 1, 0);
                continue;
            end
            e = exp_q.pop_front();
            chk("code", int'(got), int'(e.code));
            @(negedge clk);
            chk("check_sw", int'(lock_sw), 0);
            @(negedge clk);
            if (e.opened) begin
                n = 0;
                while (open && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                chk("open_len", n, e.open_len);
                chk("relock_clear", int'(lock_clear), 1);
                chk("open_fail_cnt", int'(fail_cnt), 0);
            end else begin
                chk("fail_pulse", int'(lock_clear), 1);
                chk("fail_no_open", int'(open), 0);
                @(negedge clk);
                chk("fail_cnt", int'(fail_cnt), e.fail_after);
                if (e.locks) begin
                    n = 0;
                    bad = 0;
                    while (lockout && n < 200) begin
                        if (key_ready) bad++;
                        n++;
                        @(negedge clk);
                    end
                    chk("lockout_len", n, T_LOCK);
                    chk("lockout_ready", bad, 0);
                    chk("post_lockout_cnt", int'(fail_cnt), 0);
                end else begin
                    chk("no_lockout", int'(lockout), 0);
                end
            end
            chk("ready_after", int'(key_ready), 1);
            done++;
        end
    end

    task automatic send_digit(input logic [2:0] d);
        int k = 0;
        while (!key_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!key_ready) chk("send_timeout", 0, 1);
        key_valid = 1'b1;
        key_data  = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic attempt(input logic [11:0] code, input int h);
        exp_t e;
        int   k;
        int   target;
        hold = h;
        for (int i = 0; i < 4; i++) send_digit(code[11-3*i -: 3]);
        chk("full_ready", int'(key_ready), 0);
        e.code     = code;
        e.opened   = (code == SECRET);
        e.open_len = (h < T_OPEN) ? h : T_OPEN;
        if (e.opened) begin
            fails        = 0;
            e.fail_after = 0;
            e.locks      = 1'b0;
        end else begin
            fails        = (fails < 3) ? fails + 1 : 3;
            e.fail_after = fails;
            e.locks      = (fails >= MAXF);
            if (e.locks) fails = 0;
        end
        exp_q.push_back(e);
        target = done + 1;
        k = 0;
        // Offer junk digits whenever the DUT is not ready; none may land.
        while (done < target && k < 200) begin
            key_data  = 3'($urandom);
            key_valid = ~key_ready;
            @(negedge clk);
            k++;
        end
        key_valid = 1'b0;
        if (done < target) chk("attempt_timeout", done, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        clear_n   = 1'b0;
        key_valid = 1'b0;
        key_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_lock_clear", int'(lock_clear), 1);
        chk("rst_key_ready", int'(key_ready), 0);
        chk("rst_lock_sw", int'(lock_sw), 0);
        chk("rst_open", int'(open), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        clear_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(key_ready), 1);
        chk("idle_clear", int'(lock_clear), 1);

        attempt(SECRET, 5);
        attempt(12'o0133, 20);
        attempt(12'o1111, 20);
        attempt(12'o2222, 20);
        attempt(SECRET, 1000);
        repeat (24) begin
            logic [11:0] c;
            c = ($urandom_range(0, 2) == 0) ? SECRET : 12'($urandom);
            attempt(c, int'($urandom_range(1, 40)));
        end
        attempt(SECRET, 3);

        // Reset on the second PRESENT cycle aborts without counting a failure.
        mon_en = 1'b0;
        hold   = 1000;
        for (int i = 0; i < 4; i++) send_digit(SECRET[11-3*i -: 3]);
        k = 0;
        while (lock_clear && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("abort_p1_sw", int'(lock_sw), 0);
        @(negedge clk);
        chk("abort_p2_sw", int'(lock_sw), 1);
        clear_n = 1'b0;
        #1;
        chk("abort_rst_clear", int'(lock_clear), 1);
        chk("abort_rst_ready", int'(key_ready), 0);
        chk("abort_rst_sw", int'(lock_sw), 0);
        @(negedge clk);
        clear_n = 1'b1;
        chk("abort_idle_clear", int'(lock_clear), 1);
        chk("abort_fail_cnt", int'(fail_cnt), 0);
        chk("abort_open", int'(open), 0);
        chk("abort_lockout", int'(lockout), 0);
        #1;
        chk("abort_ready", int'(key_ready), 1);
        @(negedge clk);
        mon_en = 1'b1;
        fails  = 0;
        attempt(SECRET, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter: MAX_FAIL, default 3; consecutive failed attempts that trigger lockout (range 1-3).
REQ-002 Parameter: LOCKOUT_CYCLES, default 16; lockout duration in clk cycles (minimum 1).
REQ-003 Parameter: OPEN_TIMEOUT, default 32; maximum cycles spent in OPEN before the sequencer forces relock.
REQ-004 Port: clk  in  1; the single clock, rising-edge.
REQ-005 Port: clear_n  in  1; synchronous reset, active-low.
REQ-006 Port: key_valid  in  1; keypad digit offered.
REQ-007 Port: key_data  in  3; digit value.
REQ-008 Port: key_ready  out  1; sequencer accepts the digit this cycle.
REQ-009 Port: lock_sw  out  3; digit driven to the lock's sw input.
REQ-010 Port: lock_clear  out  1; active-high clear driven to the lock.
REQ-011 Port: lock_alarm  in  1; lock alarm, active-low (0 = wrong code).
REQ-012 Port: lock_locked  in  1; lock status (0 = open).
REQ-013 Port: lock_entimer  in  1; lock's open-timer running.
REQ-014 Port: open  out  1; registered, high while the lock reports open.
REQ-015 Port: lockout  out  1; registered, high during lockout.
REQ-016 Port: fail_cnt  out  2; registered count of consecutive failures.

Function
REQ-017 The FSM SHALL have the states IDLE, PRESENT, CHECK, OPEN, FAIL and LOCKOUT.
REQ-018 In IDLE, key_ready SHALL be 1 while the 4-entry digit buffer holds fewer than 4 digits, and the digit SHALL be written to buf[wr_idx] when key_valid and key_ready are both 1.
REQ-019 In IDLE, lock_clear SHALL be 1 so that the lock is held in its initial state.
REQ-020 When the buffer holds 4 digits, the FSM SHALL move from IDLE to PRESENT on the next edge, with key_ready 0 from that cycle on.
REQ-021 PRESENT SHALL last exactly 4 cycles, with lock_clear 0, lock_sw = buf[idx] and idx = 0,1,2,3 (one digit per cycle); the FSM then SHALL enter CHECK.
REQ-022 In CHECK (1 cycle): if lock_locked is 0, the FSM SHALL go to OPEN; otherwise, if lock_alarm is 0, it SHALL go to FAIL; otherwise it SHALL go to FAIL (treated as a protocol error).
REQ-023 In OPEN, the sequencer SHALL set fail_cnt to 0 and open to 1.
REQ-024 OPEN SHALL exit to IDLE when lock_locked returns to 1, or when OPEN_TIMEOUT cycles elapse (forced relock via IDLE's lock_clear); the buffer SHALL be emptied on exit.
REQ-025 FAIL (1 cycle) SHALL assert lock_clear, increment fail_cnt (saturating at 3) and empty the buffer.
REQ-026 FAIL SHALL go to LOCKOUT if the incremented fail_cnt is at least MAX_FAIL, and to IDLE otherwise.
REQ-027 In LOCKOUT, lockout SHALL be 1, lock_clear 1 and key_ready 0, with a down-counter loaded with LOCKOUT_CYCLES-1.
REQ-028 When the LOCKOUT counter reaches 0, the FSM SHALL go to IDLE with fail_cnt cleared.
REQ-029 key_valid SHALL be ignored whenever key_ready is 0, with no buffering and no error.
REQ-030 In every state other than PRESENT, lock_sw SHALL be 0.
REQ-031 All counters SHALL be sized to their parameter via $clog2 and SHALL NOT wrap.

Reset
REQ-032 While clear_n is 0 at a clk edge: state SHALL be IDLE, buffer empty, idx 0, fail_cnt 0, open 0, lockout 0 and both timers 0.
REQ-033 During reset, lock_clear SHALL be 1, key_ready 0 and lock_sw 0.
REQ-034 Reset taken mid-PRESENT, mid-OPEN or mid-LOCKOUT SHALL abort the sequence immediately, with no failure counted.

Structure
REQ-035 The FSM state encoding and the CODE_LEN=4 constant SHALL reside in a shared package, lock_pkg.
REQ-036 The design SHALL have one sub-module, lock_timer: a loadable down-counter with a zero flag, instantiated once and shared by OPEN and LOCKOUT.

Verification
REQ-037 Keys 0,1,2,3 entered with the lock attached -> 4 PRESENT cycles, CHECK sees lock_locked=0, open=1, then return to IDLE when lock_locked=1; fail_cnt=0.
REQ-038 Keys 0,1,3,3 -> FAIL pulses lock_clear for 1 cycle, fail_cnt=1, back in IDLE with key_ready=1.
REQ-039 Three wrong codes in a row -> lockout=1 for exactly 16 cycles, key_valid ignored throughout, then fail_cnt=0 and return to IDLE.
REQ-040 Fifth key_valid while 4 digits are buffered -> key_ready=0 and the digit is dropped; the presented sequence equals the first 4 digits.
REQ-041 Lock model held open (lock_locked=0) -> forced exit from OPEN after 32 cycles, with lock_clear=1 in the next cycle.
REQ-042 clear_n=0 on the 2nd PRESENT cycle -> next cycle is IDLE, fail_cnt unchanged at 0, lock_clear=1.
